// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer. Operands are latched on an
// accepted start, then stepped LSB-first through one shared full adder
// (two half_adder cells plus an OR), one bit per clock.
// Optional build macro SERIAL_ADDER_SUB_EN adds the sub input (a-b) and the
// ovf output (signed overflow).

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [WIDTH-1:0] b_load;
  logic             carry, carry_load, carry_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load, last;
  logic             s0, c0, c1, s_bit;

  // Shared 1-bit full adder: two half adders, carries merged by an OR.
  half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s0),    .c(c0));
  half_adder u_ha1 (.x(s0),      .y(carry),   .s(s_bit), .c(c1));
  assign carry_nxt = c0 | c1;

  // A new operation may be accepted from IDLE or straight out of DONE.
  assign load = start && (state != RUN);
  assign last = (cnt == CNT_W'(WIDTH-1));

  // Result bits enter at the MSB so that after WIDTH steps bit 0 is in place.
  assign res_nxt = {s_bit, {(WIDTH-1){1'b0}}} | (res_sr >> 1);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; the forced carry replaces cin.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load, per-bit stepping, and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= carry_nxt;
      res_sr <= res_nxt;
      if (last) begin
        sum  <= res_nxt;
        cout <= carry_nxt;
`ifdef SERIAL_ADDER_SUB_EN
        // Carry into the MSB is the current carry; carry out is carry_nxt.
        ovf  <= carry ^ carry_nxt;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit and a 64-bit instance.
// Expected results are pushed when a start is accepted and popped on done.
module tb_serial_adder_ctrl;
  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 0, rst_n = 0;
  logic        start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, sum8;
  logic        busy8, done8, cout8;
  logic        start64 = 0, cin64 = 0, sub64 = 0;
  logic [63:0] a64 = 0, b64 = 0, sum64;
  logic        busy64, done64, cout64;
`ifdef SERIAL_ADDER_SUB_EN
  logic        ovf8, ovf64;
`endif

  exp_t q8[$], q64[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   rem8 = 0, rem64 = 0, ndone8 = 0, last8 = 0, prev8 = 0;
  bit   dexp8 = 0, dexp64 = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8), .ovf(ovf8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder_ctrl #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .a(a64), .b(b64), .cin(cin64),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub64), .ovf(ovf64),
`endif
    .busy(busy64), .done(done64), .sum(sum64), .cout(cout64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference arithmetic, computed word-wide rather than bit by bit.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input int c0);
    logic [64:0] m, mlo, full, lo;
    logic [63:0] bb;
    logic        c;
    exp_t        e;
    m    = (65'd1 << w) - 65'd1;
    mlo  = (65'd1 << (w - 1)) - 65'd1;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a & m[63:0]} + {1'b0, bb & m[63:0]} + {64'd0, c};
    lo   = {1'b0, a & mlo[63:0]} + {1'b0, bb & mlo[63:0]} + {64'd0, c};
    e.sum  = full[63:0] & m[63:0];
    e.cout = full[w];
    e.ovf  = lo[w-1] ^ full[w];
    e.cyc  = c0;
    return e;
  endfunction

  // Independent busy/done timeline and scoreboard push on accepted starts.
  always @(posedge clk) begin
    cyc++;
    dexp8  = 0;
    dexp64 = 0;
    if (!rst_n) rem8 = 0;
    else if (rem8 > 0) begin rem8--; dexp8 = (rem8 == 0); end
    else if (start8) begin
      q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, cin8, sub8, cyc));
      rem8 = 8;
    end
    if (!rst_n) rem64 = 0;
    else if (rem64 > 0) begin rem64--; dexp64 = (rem64 == 0); end
    else if (start64) begin
      q64.push_back(model(64, a64, b64, cin64, sub64, cyc));
      rem64 = 64;
    end
  end

  // Output checks away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy8", busy8, rem8 > 0);
      chk("done8", done8, dexp8);
      chk("busy64", busy64, rem64 > 0);
      chk("done64", done64, dexp64);
      if (dexp8) begin
        ndone8++; prev8 = last8; last8 = cyc;
        if (q8.size() == 0) chk("q8_underflow", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sum8", sum8, e.sum);
          chk("cout8", cout8, e.cout);
          chk("lat8", cyc - e.cyc, 8);
`ifdef SERIAL_ADDER_SUB_EN
          chk("ovf8", ovf8, e.ovf);
`endif
        end
      end
      if (dexp64) begin
        if (q64.size() == 0) chk("q64_underflow", 1, 0);
        else begin
          e = q64.pop_front();
          chk("sum64", sum64, e.sum);
          chk("cout64", cout64, e.cout);
          chk("lat64", cyc - e.cyc, 64);
`ifdef SERIAL_ADDER_SUB_EN
          chk("ovf64", ovf64, e.ovf);
`endif
        end
      end
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    @(negedge clk); a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1;
    @(negedge clk); start8 = 0;
  endtask

  task automatic go64(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
    @(negedge clk); a64 = a; b64 = b; cin64 = c; sub64 = s; start64 = 1;
    @(negedge clk); start64 = 0;
  endtask

  task automatic wait8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) chk("timeout8", q8.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait64();
    for (int i = 0; i < 300 && q64.size() != 0; i++) @(negedge clk);
    if (q64.size() != 0) chk("timeout64", q64.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset values, no clock edge needed.
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_sum64", sum64, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Simple add with exact latency.
    go8(8'h0F, 8'h01, 0, 0);
    wait8();
    chk("t2_sum", sum8, 8'h10);
    chk("t2_cout", cout8, 0);

    // Full carry chain, then hold while idle.
    go8(8'hFF, 8'h01, 1, 0);
    wait8();
    repeat (20) @(negedge clk);
    chk("t3_hold_sum", sum8, 8'h01);
    chk("t3_hold_cout", cout8, 1);

    // Back-to-back with start held through DONE.
    n0 = ndone8;
    @(negedge clk); a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1;
    @(negedge clk); a8 = 8'h01; b8 = 8'h02;
    for (int i = 0; i < 40 && ndone8 == n0; i++) @(negedge clk);
    @(negedge clk); start8 = 0;
    wait8();
    chk("t4_sum", sum8, 8'h03);
    chk("t4_gap", last8 - prev8, 9);

    // Start during RUN is ignored.
    go8(8'h33, 8'h44, 0, 0);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; start8 = 1;
    @(negedge clk); start8 = 0;
    wait8();
    chk("t5_sum", sum8, 8'h77);

    // Reset mid-RUN: abort, no done, sum cleared.
    go8(8'h12, 8'h34, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_busy", busy8, 0);
    chk("t5_rst_done", done8, 0);
    chk("t5_rst_sum", sum8, 0);
    q8.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (12) @(negedge clk);
    chk("t5_post_sum", sum8, 0);

    // Random operands.
    for (int i = 0; i < 6; i++) begin
      go8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      wait8();
    end

`ifdef SERIAL_ADDER_SUB_EN
    go8(8'h05, 8'h07, 0, 1);
    wait8();
    chk("sub_sum", sum8, 8'hFE);
    go8(8'h80, 8'h01, 1, 1);
    wait8();
    chk("sub_ovf", ovf8, 1);
    go8(8'h7F, 8'h01, 0, 0);
    wait8();
    chk("add_ovf", ovf8, 1);
    go64(64'h8000_0000_0000_0000, 64'd1, 0, 1);
    wait64();
    chk("t6_sum", sum64, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t6_ovf", ovf64, 1);
`endif

    // Wide operand, carry through all 64 bits.
    go64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    wait64();
    chk("w64_sum", sum64, 64'd0);
    chk("w64_cout", cout64, 1);
    go64({$urandom, $urandom}, {$urandom, $urandom}, 1, 0);
    wait64();

    chk("q_empty", q8.size() + q64.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
